// File: rtl/stack_access_unit_if.sv
// Bundle of command, ESP-register, memory and response signals around the stack access unit.
// slave = the unit itself; master = control unit / ESP register / memory side.
interface stack_access_unit_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_op;
    logic [DATA_W-1:0] cmd_data;
    logic [ADDR_W-1:0] esp_in;
    logic              esp_wr;
    logic [ADDR_W-1:0] esp_next;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_data;
    logic              fault;

    modport slave (
        input  cmd_valid, cmd_op, cmd_data, esp_in, mem_ack, mem_rdata,
        output cmd_ready, esp_wr, esp_next, mem_req, mem_we, mem_addr, mem_wdata,
               rsp_valid, rsp_data, fault
    );

    modport master (
        output cmd_valid, cmd_op, cmd_data, esp_in, mem_ack, mem_rdata,
        input  cmd_ready, esp_wr, esp_next, mem_req, mem_we, mem_addr, mem_wdata,
               rsp_valid, rsp_data, fault
    );
endinterface

// File: rtl/stack_access_unit.sv
// Executes PUSH/POP/PEEK against stack memory and returns the updated ESP; accept to rsp_valid = 2 cycles + memory wait.
// Backpressure: cmd_ready only in IDLE; mem_req held until mem_ack. Optional bounds check: STACK_BOUNDS_CHECK_EN.
module stack_access_unit #(
    parameter int                DATA_W      = 32,
    parameter int                ADDR_W      = 32,
    parameter int                WORD_BYTES  = 4,
    parameter logic [ADDR_W-1:0] STACK_LIMIT = '0,
    parameter logic [ADDR_W-1:0] STACK_BASE  = 32'hFFFF_FFFC
) (
    input  logic                 clk,
    input  logic                 reset,
    stack_access_unit_if.slave   bus
);

    localparam logic [1:0] OP_PUSH = 2'b00;
    localparam logic [1:0] OP_POP  = 2'b01;
    localparam logic [1:0] OP_PEEK = 2'b10;
    localparam logic [1:0] OP_RSVD = 2'b11;

    localparam logic [ADDR_W-1:0] STEP = ADDR_W'(WORD_BYTES);

`ifdef STACK_BOUNDS_CHECK_EN
    localparam bit CHECK_EN = 1'b1;
`else
    localparam bit CHECK_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t state_q, state_d;
    logic   accept;

    logic [1:0]        op_q;
    logic              we_q;
    logic              fault_q;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] esp_next_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rsp_data_q;

    logic [ADDR_W-1:0] push_addr;
    logic [ADDR_W-1:0] pop_esp;
    logic              violation;
    logic              bad_cmd;
    logic              skip_mem;

    // Wrap-around is intended: ESP arithmetic is modulo 2^ADDR_W.
    assign push_addr = bus.esp_in - STEP;
    assign pop_esp   = bus.esp_in + STEP;

    always_comb begin
        violation = 1'b0;
        case (bus.cmd_op)
            OP_PUSH:         violation = (push_addr < STACK_LIMIT);
            OP_POP, OP_PEEK: violation = (bus.esp_in > STACK_BASE);
            default:         violation = 1'b0;
        endcase
    end

    assign bad_cmd  = CHECK_EN && violation;
    assign skip_mem = (bus.cmd_op == OP_RSVD) || bad_cmd;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.cmd_valid) begin
                    accept  = 1'b1;
                    state_d = skip_mem ? DONE : REQ;
                end
            end
            REQ: begin
                if (bus.mem_ack) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Everything the command needs is captured at accept, so esp_in may move afterwards.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_q       <= OP_PUSH;
            we_q       <= 1'b0;
            fault_q    <= 1'b0;
            addr_q     <= '0;
            esp_next_q <= '0;
            wdata_q    <= '0;
            rsp_data_q <= '0;
        end else begin
            if (accept) begin
                op_q    <= bus.cmd_op;
                we_q    <= (bus.cmd_op == OP_PUSH);
                fault_q <= bad_cmd;
                addr_q  <= (bus.cmd_op == OP_PUSH) ? push_addr : bus.esp_in;
                wdata_q <= (bus.cmd_op == OP_PUSH) ? bus.cmd_data : '0;
                case (bus.cmd_op)
                    OP_PUSH: esp_next_q <= push_addr;
                    OP_POP:  esp_next_q <= pop_esp;
                    default: esp_next_q <= bus.esp_in;
                endcase
                if (skip_mem) begin
                    rsp_data_q <= '0;
                end
            end
            // Result changes only on the edge that raises rsp_valid.
            if ((state_q == REQ) && bus.mem_ack) begin
                rsp_data_q <= we_q ? '0 : bus.mem_rdata;
            end
        end
    end

    assign bus.cmd_ready = (state_q == IDLE);
    assign bus.mem_req   = (state_q == REQ);
    assign bus.mem_we    = (state_q == REQ) && we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.rsp_valid = (state_q == DONE);
    assign bus.rsp_data  = rsp_data_q;
    assign bus.esp_next  = esp_next_q;
    assign bus.esp_wr    = (state_q == DONE) && !fault_q &&
                           ((op_q == OP_PUSH) || (op_q == OP_POP));

`ifdef STACK_BOUNDS_CHECK_EN
    assign bus.fault = (state_q == DONE) && fault_q;
`else
    assign bus.fault = 1'b0;
`endif

endmodule

// File: tb/tb_stack_access_unit.sv
// Randomized bench for stack_access_unit with an ESP/memory reference model (default build, no bounds check).
module tb_stack_access_unit;

    logic clk;
    logic reset;
    int   n_tests = 0;
    int   n_fail  = 0;

    logic [31:0] last_rsp;
    bit          hold_known;

    stack_access_unit_if #(.DATA_W(32), .ADDR_W(32)) bus ();

    stack_access_unit dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One command end to end; the model computes address, ESP update, result and latency from the op rules.
    task automatic run_cmd(input logic [1:0] op, input logic [31:0] esp, input logic [31:0] data,
                           input int wait_cyc, input logic [31:0] rdata);
        bit          exp_mem;
        bit          exp_wr;
        logic [31:0] exp_addr;
        logic [31:0] exp_next;
        int          exp_lat;
        int          n;
        int          k;
        bit          done;

        exp_mem  = (op != 2'b11);
        exp_wr   = (op == 2'b00) || (op == 2'b01);
        exp_addr = (op == 2'b00) ? esp - 32'd4 : esp;
        exp_next = (op == 2'b00) ? esp - 32'd4 : (op == 2'b01) ? esp + 32'd4 : esp;
        exp_lat  = exp_mem ? 2 + wait_cyc : 1;

        @(negedge clk);
        check("cmd_ready_idle", {31'd0, bus.cmd_ready}, 32'd1);
        if (hold_known) check("rsp_data_hold", bus.rsp_data, last_rsp);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_data  = data;
        bus.esp_in    = esp;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        bus.esp_in    = $urandom;
        bus.cmd_data  = $urandom;
        n    = 1;
        k    = 0;
        done = 1'b0;
        while (!done && n <= 60) begin
            check("cmd_ready_busy", {31'd0, bus.cmd_ready}, 32'd0);
            if (bus.mem_req) begin
                check("mem_req_expected", {31'd0, exp_mem}, 32'd1);
                check("mem_addr", bus.mem_addr, exp_addr);
                check("mem_we", {31'd0, bus.mem_we}, {31'd0, op == 2'b00});
                if (op == 2'b00) check("mem_wdata", bus.mem_wdata, data);
                bus.mem_ack   = (k == wait_cyc);
                bus.mem_rdata = (k == wait_cyc) ? rdata : $urandom;
                k++;
            end else begin
                bus.mem_ack   = $urandom_range(0, 1);
                bus.mem_rdata = $urandom;
            end
            if (bus.rsp_valid) begin
                done = 1'b1;
                check("latency", n, exp_lat);
                check("req_cycles", k, exp_mem ? wait_cyc + 1 : 0);
                check("esp_wr", {31'd0, bus.esp_wr}, {31'd0, exp_wr});
                if (exp_wr) check("esp_next", bus.esp_next, exp_next);
                check("fault", {31'd0, bus.fault}, 32'd0);
                if (op != 2'b00) begin
                    check("rsp_data", bus.rsp_data, (op == 2'b11) ? 32'd0 : rdata);
                    last_rsp   = (op == 2'b11) ? 32'd0 : rdata;
                    hold_known = 1'b1;
                end else begin
                    hold_known = 1'b0;
                end
            end else if (bus.esp_wr) begin
                check("esp_wr_early", {31'd0, bus.esp_wr}, 32'd0);
            end
            @(negedge clk);
            n++;
        end
        if (!done) check("rsp_timeout", 32'd0, 32'd1);
        check("rsp_valid_pulse", {31'd0, bus.rsp_valid}, 32'd0);
        bus.mem_ack = 1'b0;
    endtask

    initial begin
        logic [31:0] esp_reg;
        logic [1:0]  op;
        logic [31:0] d;

        reset         = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 2'b00;
        bus.cmd_data  = '0;
        bus.esp_in    = '0;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = '0;
        hold_known    = 1'b0;
        last_rsp      = '0;

        repeat (2) @(negedge clk);
        check("rst_cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);
        check("rst_mem_req", {31'd0, bus.mem_req}, 32'd0);
        check("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        check("rst_esp_wr", {31'd0, bus.esp_wr}, 32'd0);
        check("rst_esp_next", bus.esp_next, 32'd0);
        check("rst_rsp_data", bus.rsp_data, 32'd0);
        check("rst_mem_addr", bus.mem_addr, 32'd0);
        check("rst_fault", {31'd0, bus.fault}, 32'd0);
        reset = 1'b0;

        run_cmd(2'b00, 32'h0000_0100, 32'hDEAD_BEEF, 2, 32'h0);
        run_cmd(2'b01, 32'h0000_00FC, 32'h0, 1, 32'h1234_5678);
        run_cmd(2'b10, 32'h0000_0080, 32'h0, 0, 32'hCAFE_F00D);
        run_cmd(2'b00, 32'h0000_0000, 32'h5555_AAAA, 0, 32'h0);
        run_cmd(2'b01, 32'hFFFF_FFFC, 32'h0, 3, 32'h0BAD_F00D);

        // Stray acks while idle must not start anything.
        @(negedge clk);
        bus.mem_ack = 1'b1;
        repeat (2) @(negedge clk);
        check("stray_ack_req", {31'd0, bus.mem_req}, 32'd0);
        check("stray_ack_rsp", {31'd0, bus.rsp_valid}, 32'd0);
        check("stray_ack_ready", {31'd0, bus.cmd_ready}, 32'd1);
        bus.mem_ack = 1'b0;
        run_cmd(2'b11, 32'h0000_0400, 32'h1111_2222, 0, 32'h0);

        // Reset while a request is outstanding.
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = 2'b00;
        bus.cmd_data  = 32'h7777_7777;
        bus.esp_in    = 32'h0000_2000;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        check("midop_req_before", {31'd0, bus.mem_req}, 32'd1);
        #1 reset = 1'b1;
        #1;
        check("midop_req_drop", {31'd0, bus.mem_req}, 32'd0);
        check("midop_ready", {31'd0, bus.cmd_ready}, 32'd1);
        @(negedge clk);
        reset = 1'b0;
        bus.mem_ack = 1'b1;
        @(negedge clk);
        bus.mem_ack = 1'b0;
        repeat (3) begin
            check("midop_no_rsp", {31'd0, bus.rsp_valid | bus.esp_wr}, 32'd0);
            @(negedge clk);
        end
        hold_known = 1'b1;
        last_rsp   = 32'd0;
        run_cmd(2'b01, 32'h0000_2000, 32'h0, 1, 32'hA5A5_5A5A);

        // Random traffic following an ESP register kept by the bench.
        esp_reg = 32'h0001_0000;
        for (int i = 0; i < 150; i++) begin
            op = 2'($urandom_range(0, 3));
            d  = $urandom;
            case ($urandom_range(0, 9))
                0:       esp_reg = 32'h0;
                1:       esp_reg = 32'hFFFF_FFFC;
                2:       esp_reg = $urandom & 32'hFFFF_FFFC;
                default: ;
            endcase
            run_cmd(op, esp_reg, d, $urandom_range(0, 3), $urandom);
            if (op == 2'b00) esp_reg = esp_reg - 32'd4;
            else if (op == 2'b01) esp_reg = esp_reg + 32'd4;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
